// File: rtl/diffeq_trace_buffer_if.sv
// diffeq_trace_buffer_if: drain port for captured solver samples (valid/ready plus x/y/u payload)
//   out_valid  head FIFO entry is available (driven by the buffer)
//   out_ready  consumer accepts the head entry (driven by the consumer)
//   out_x/y/u  payload of the head entry (driven by the buffer)
interface diffeq_trace_buffer_if #(parameter int WIDTH = 32);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_x;
   logic [WIDTH-1:0] out_y;
   logic [WIDTH-1:0] out_u;
   modport master (output out_valid, out_x, out_y, out_u, input out_ready);
   modport slave  (input out_valid, out_x, out_y, out_u, output out_ready);
endinterface

// File: rtl/diffeq_trace_buffer.sv
// diffeq_trace_buffer: records decimated (x,y,u) solver samples into a FIFO and flags run completion
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             1-cycle pulse arming a capture run
//   aport             solver bound a (solver halts when x >= a)
//   xport/yport/uport solver state being watched
//   bus               sample drain port (valid/ready, x/y/u of the FIFO head)
//   done              run complete, held until start or reset
//   overflow          sticky flag: a kept sample was dropped on a full FIFO
//   drop_cnt          count of dropped samples, saturating at 255
module diffeq_trace_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int DECIM = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      aport,
   input  logic [WIDTH-1:0]      xport,
   input  logic [WIDTH-1:0]      yport,
   input  logic [WIDTH-1:0]      uport,
   diffeq_trace_buffer_if.master bus,
   output logic                  done,
   output logic                  overflow,
   output logic [7:0]            drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
   typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, HALTED, DONE} state_t;
   state_t             state, state_nx;
   logic [WIDTH-1:0]   x_prev;
   logic [CW-1:0]      dcnt, dcnt_base;
   logic [3*WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic               step, restart, take, keep, arm, full, pop, push, drop;
   // Any change of x marks a solver iteration; a decrease means the solver restarted.
   assign step      = xport != x_prev;
   assign restart   = xport < x_prev;
   assign take      = step && (state inside {ARMED, CAPTURE, HALTED});
   assign dcnt_base = restart ? '0 : dcnt;
   assign keep      = take && dcnt_base == '0;
   assign arm       = start && (state == IDLE || state == DONE);
   assign full      = count == (AW+1)'(DEPTH);
   assign pop       = bus.out_valid && bus.out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves.
   assign push      = keep && (!full || pop);
   assign drop      = keep && full && !pop;
   assign bus.out_valid = count != '0;
   assign {bus.out_x, bus.out_y, bus.out_u} = bus.out_valid ? mem[rd_ptr] : '0;
   assign done      = state == DONE;
   always_comb begin
      state_nx = take ? CAPTURE :
                 arm ? ARMED :
                 (state == CAPTURE && xport >= aport) ? HALTED :
                 (state == HALTED && count == '0) ? DONE : state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         x_prev   <= '0;
         dcnt     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state  <= state_nx;
         x_prev <= xport;
         if (arm) begin
            dcnt     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
         if (take) dcnt <= dcnt_base == CW'(DECIM - 1) ? '0 : dcnt_base + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {xport, yport, uport};
   end
endmodule

// File: tb/tb_diffeq_trace_buffer.sv
// tb_diffeq_trace_buffer: directed and randomized bench for diffeq_trace_buffer against a queue-based model
module tb_diffeq_trace_buffer;
   localparam int DEPTH = 16;
   localparam int DECIM = 3;
   localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_HALT = 3, M_DONE = 4;
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] u;
   } smp_t;
   logic        clk = 1'b0;
   logic        reset, start, done, overflow;
   logic [31:0] a, x, y, u;
   logic [7:0]  drop_cnt;
   int          checks = 0, passes = 0;
   smp_t        mq[$];
   int          mph = M_IDLE, mdc = 0, mdrops = 0;
   logic        movf = 1'b0;
   logic [31:0] mxprev = '0;
   diffeq_trace_buffer_if #(.WIDTH(32)) bus ();
   diffeq_trace_buffer #(.WIDTH(32), .DEPTH(DEPTH), .DECIM(DECIM)) dut (
      .clk(clk), .reset(reset), .start(start), .aport(a), .xport(x), .yport(y), .uport(u),
      .bus(bus), .done(done), .overflow(overflow), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Reference: one iteration per change of x, keep every DECIM-th since arm/restart, bounded queue.
   task automatic model_update();
      logic stp, rs, pop, push, full;
      smp_t s;
      stp = x != mxprev;
      rs = x < mxprev;
      s = '{x: x, y: y, u: u};
      if (reset) begin
         mph = M_IDLE; mq.delete(); mxprev = '0; mdc = 0; movf = 1'b0; mdrops = 0;
      end else begin
         pop = mq.size() != 0 && bus.out_ready;
         full = mq.size() == DEPTH;
         push = 1'b0;
         if (stp && (mph == M_ARMED || mph == M_CAPT || mph == M_HALT)) begin
            if (rs) mdc = 0;
            push = mdc == 0;
            mdc = (mdc + 1) % DECIM;
            mph = M_CAPT;
         end else if (start && (mph == M_IDLE || mph == M_DONE)) begin
            mph = M_ARMED; movf = 1'b0; mdrops = 0; mdc = 0;
         end else if (mph == M_CAPT && x >= a) mph = M_HALT;
         else if (mph == M_HALT && mq.size() == 0) mph = M_DONE;
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (full && !pop) begin
               movf = 1'b1;
               if (mdrops < 255) mdrops++;
            end else mq.push_back(s);
         end
         mxprev = x;
      end
   endtask
   task automatic compare();
      smp_t h;
      chk("out_valid", bus.out_valid, mq.size() != 0);
      chk("done", done, mph == M_DONE);
      chk("overflow", overflow, movf);
      chk("drop_cnt", drop_cnt, mdrops);
      if (mq.size() != 0) begin
         h = mq[0];
         chk("out_x", bus.out_x, h.x);
         chk("out_y", bus.out_y, h.y);
         chk("out_u", bus.out_u, h.u);
      end
   endtask
   initial forever begin
      @(posedge clk);
      model_update();
   end
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         compare();
      end
   end
   task automatic stepx(input logic [31:0] v);
      x = v;
      y = $urandom;
      u = $urandom;
      tick();
   endtask
   task automatic pop_expect(input string nm, input logic [31:0] ex);
      chk({nm, "_valid"}, bus.out_valid, 1);
      chk(nm, bus.out_x, ex);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   initial begin
      int n, r, rp;
      reset = 1'b1; start = 1'b0; a = '0; x = '0; y = '0; u = '0; bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      // Decimation by 3 over x=1..7 keeps 1, 4, 7.
      a = 100;
      pulse_start();
      for (int i = 1; i <= 7; i++) stepx(i);
      pop_expect("decim_1", 1);
      pop_expect("decim_4", 4);
      pop_expect("decim_7", 7);
      a = 7;
      repeat (3) tick();
      chk("halt_done", done, 1);
      // Fill exactly 16, then push with a simultaneous pop: nothing dropped.
      a = 1000;
      pulse_start();
      chk("rearm_done", done, 0);
      for (int i = 8; i <= 55; i++) stepx(i);
      chk("model_full", mq.size(), 16);
      chk("full_head", bus.out_x, 8);
      bus.out_ready = 1'b1;
      stepx(56);
      bus.out_ready = 1'b0;
      chk("pushpop_overflow", overflow, 0);
      chk("pushpop_drops", drop_cnt, 0);
      chk("pushpop_head", bus.out_x, 11);
      // Four more kept samples (59, 62, 65, 68) all land on a full FIFO.
      for (int i = 57; i <= 68; i++) stepx(i);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drops", drop_cnt, 4);
      n = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40 && bus.out_valid; i++) begin
         n++;
         tick();
      end
      bus.out_ready = 1'b0;
      chk("drain_count", n, 16);
      a = 68;
      repeat (3) tick();
      chk("drain_done", done, 1);
      // Solver restart: x drops back, the restart sample is kept and counting restarts.
      a = 1000;
      pulse_start();
      chk("rearm_overflow", overflow, 0);
      stepx(9);
      stepx(10);
      stepx(0);
      stepx(1);
      stepx(2);
      stepx(3);
      pop_expect("restart_9", 9);
      pop_expect("restart_0", 0);
      pop_expect("restart_3", 3);
      // Reset while capturing with 5 entries held.
      for (int i = 4; i <= 18; i++) stepx(i);
      chk("held_five", mq.size(), 5);
      chk("held_head", bus.out_x, 6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_done", done, 0);
      chk("midrst_overflow", overflow, 0);
      chk("midrst_drops", drop_cnt, 0);
      rp = 60;
      for (int c = 0; c < 3000; c++) begin
         reset = $urandom_range(0, 599) == 0;
         start = $urandom_range(0, 29) == 0;
         r = $urandom_range(0, 99);
         if (r < 55) x = x + 1;
         else if (r < 60) x = 0;
         else if (r < 63) x = $urandom_range(0, 50);
         if (start) begin
            a = x + $urandom_range(0, 40);
            rp = ($urandom_range(0, 2) == 0) ? 5 : (($urandom_range(0, 1) == 0) ? 60 : 95);
         end
         bus.out_ready = $urandom_range(0, 99) < rp;
         y = $urandom;
         u = $urandom;
         tick();
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
